// File: rtl/imem_boot_loader_pkg.sv
// Shared state encoding and helpers for the instruction-memory boot loader.
package imem_boot_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR0  = 3'd1,
        ST_HDR1  = 3'd2,
        ST_LOAD  = 3'd3,
        ST_CHK   = 3'd4,
        ST_DONE  = 3'd5,
        ST_ERROR = 3'd6
    } loader_state_t;

    // States in which the loader consumes stream bytes and reports busy.
    function automatic logic state_busy(input loader_state_t st);
        return (st == ST_HDR0) || (st == ST_HDR1) || (st == ST_LOAD) || (st == ST_CHK);
    endfunction

    // A load may only be (re)started from a quiescent state.
    function automatic logic state_startable(input loader_state_t st);
        return (st == ST_IDLE) || (st == ST_DONE) || (st == ST_ERROR);
    endfunction

endpackage

// File: rtl/imem_boot_loader_if.sv
// Boot loader control, byte stream and instruction-memory write bundle.
interface imem_boot_loader_if #(
    parameter int ADDR_WIDTH = 9
);
    logic                  start;
    logic                  in_valid;
    logic [7:0]            in_byte;
    logic                  in_ready;
    logic                  imem_we;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [31:0]           imem_wdata;
    logic                  cpu_reset;
    logic                  busy;
    logic                  done;
    logic                  error;
    logic [15:0]           words_loaded;

    modport master (
        output start, in_valid, in_byte,
        input  in_ready, imem_we, imem_addr, imem_wdata,
        input  cpu_reset, busy, done, error, words_loaded
    );

    modport slave (
        input  start, in_valid, in_byte,
        output in_ready, imem_we, imem_addr, imem_wdata,
        output cpu_reset, busy, done, error, words_loaded
    );
endinterface

// File: rtl/imem_boot_loader_byte_word_assembler.sv
// Collects four stream bytes into a little-endian word.
// Latency: word_vld one cycle after byte 3 is taken; never stalls the stream.
// Backpressure: none of its own; the caller gates byte_vld.
module byte_word_assembler (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_vld,
    input  logic [7:0]  byte_dat,
    output logic [1:0]  byte_idx,
    output logic        word_vld,
    output logic [31:0] word_dat
);

    logic [23:0] part_q;

    // word_dat is a separate register so the next word can start filling during the write cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            byte_idx <= 2'd0;
            part_q   <= 24'd0;
            word_vld <= 1'b0;
            word_dat <= 32'd0;
        end else begin
            word_vld <= 1'b0;
            if (clear) begin
                byte_idx <= 2'd0;
                part_q   <= 24'd0;
            end else if (byte_vld) begin
                byte_idx <= byte_idx + 2'd1;
                case (byte_idx)
                    2'd0:    part_q[7:0]   <= byte_dat;
                    2'd1:    part_q[15:8]  <= byte_dat;
                    2'd2:    part_q[23:16] <= byte_dat;
                    default: begin
                        word_dat <= {byte_dat, part_q};
                        word_vld <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: 2-byte LE word count, then payload words written to imem; LOADER_CHECKSUM_EN adds an XOR byte.
// Latency: imem write one cycle after each word's last byte; done rises with the final write.
// Backpressure: in_ready tracks state only; in_valid low stalls forever, no timeout.
module imem_boot_loader #(
    parameter int ADDR_WIDTH = 9,
    parameter int BASE_ADDR  = 0,
    parameter int MAX_WORDS  = 128
) (
    input  logic                clk,
    input  logic                reset,
    imem_boot_loader_if.slave   bus
);
    import imem_boot_loader_pkg::*;

    localparam logic [ADDR_WIDTH-1:0] BASE  = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [15:0]           MAX_N = 16'(MAX_WORDS);

    loader_state_t         state_q, state_d;
    logic [7:0]            hdr_lo_q;
    logic [15:0]           word_cnt_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [15:0]           wl_q;
    logic [15:0]           hdr_n;
    logic                  accept, start_ok, load_acc, last_byte;
    logic [1:0]            byte_idx;
    logic                  word_vld;
    logic [31:0]           word_dat;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]            csum_q;
`endif

    assign accept    = bus.in_valid & bus.in_ready;
    assign start_ok  = bus.start & state_startable(state_q);
    assign load_acc  = accept & (state_q == ST_LOAD);
    assign hdr_n     = {bus.in_byte, hdr_lo_q};
    // Previous word's count update always lands before this word's byte 3 can arrive.
    assign last_byte = load_acc & (byte_idx == 2'd3) & ((wl_q + 16'd1) == word_cnt_q);

    byte_word_assembler u_asm (
        .clk      (clk),
        .reset    (reset),
        .clear    (start_ok),
        .byte_vld (load_acc),
        .byte_dat (bus.in_byte),
        .byte_idx (byte_idx),
        .word_vld (word_vld),
        .word_dat (word_dat)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: if (start_ok) state_d = ST_HDR0;
            ST_HDR0: if (accept) state_d = ST_HDR1;
            ST_HDR1: begin
                if (accept) begin
                    if (hdr_n == 16'd0)     state_d = ST_DONE;
                    else if (hdr_n > MAX_N) state_d = ST_ERROR;
                    else                    state_d = ST_LOAD;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            ST_LOAD: if (last_byte) state_d = ST_CHK;
            ST_CHK:  if (accept) state_d = (bus.in_byte == csum_q) ? ST_DONE : ST_ERROR;
`else
            ST_LOAD: if (last_byte) state_d = ST_DONE;
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hdr_lo_q   <= 8'd0;
            word_cnt_q <= 16'd0;
            addr_q     <= BASE;
            wl_q       <= 16'd0;
        end else if (start_ok) begin
            hdr_lo_q   <= 8'd0;
            word_cnt_q <= 16'd0;
            addr_q     <= BASE;
            wl_q       <= 16'd0;
        end else begin
            if (accept && state_q == ST_HDR0) hdr_lo_q   <= bus.in_byte;
            if (accept && state_q == ST_HDR1) word_cnt_q <= hdr_n;
            if (word_vld) begin
                addr_q <= addr_q + ADDR_WIDTH'(4);
                wl_q   <= wl_q + 16'd1;
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)        csum_q <= 8'd0;
        else if (start_ok) csum_q <= 8'd0;
        else if (load_acc) csum_q <= csum_q ^ bus.in_byte;
    end
`endif

    assign bus.in_ready     = state_busy(state_q);
    assign bus.busy         = state_busy(state_q);
    assign bus.done         = (state_q == ST_DONE);
    assign bus.error        = (state_q == ST_ERROR);
    assign bus.cpu_reset    = (state_q != ST_DONE);
    assign bus.imem_we      = word_vld;
    assign bus.imem_wdata   = word_dat;
    assign bus.imem_addr    = addr_q;
    assign bus.words_loaded = wl_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: vector table, hand sequences, randomized loads.
module tb_imem_boot_loader;

    localparam int AW   = 9;
    localparam int BASE = 0;
    localparam int MAXW = 128;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    imem_boot_loader_if #(.ADDR_WIDTH(AW)) bus ();

    imem_boot_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [AW-1:0] wr_addr[$];
    logic [31:0]   wr_dat[$];
    logic          wr_done[$];
    logic [31:0]   pay_q[$];

    typedef struct {
        logic [15:0] n;
        logic [31:0] w0;
        logic [31:0] w1;
        int          gap;
        bit          exp_done;
        int          exp_wl;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
        end
    endtask

    // Capture every imem write strobe, even while reset is asserted.
    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            wr_addr.push_back(bus.imem_addr);
            wr_dat.push_back(bus.imem_wdata);
            wr_done.push_back(bus.done);
        end
    end

    task automatic idle(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        bus.in_valid = 1'b1;
        bus.in_byte  = b;
        while (1) begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) break;
            t++;
            if (t > 50) begin
                chk("ready_timeout", {31'd0, bus.in_ready}, 32'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic clear_log();
        wr_addr.delete();
        wr_dat.delete();
        wr_done.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        @(negedge clk);
        chk({tag, "_in_ready"},  {31'd0, bus.in_ready},  32'd0);
        chk({tag, "_imem_we"},   {31'd0, bus.imem_we},   32'd0);
        chk({tag, "_imem_addr"}, 32'(bus.imem_addr),     32'(BASE));
        chk({tag, "_wdata"},     bus.imem_wdata,         32'd0);
        chk({tag, "_cpu_reset"}, {31'd0, bus.cpu_reset}, 32'd1);
        chk({tag, "_busy"},      {31'd0, bus.busy},      32'd0);
        chk({tag, "_done"},      {31'd0, bus.done},      32'd0);
        chk({tag, "_error"},     {31'd0, bus.error},     32'd0);
        chk({tag, "_wl"},        32'(bus.words_loaded),  32'd0);
    endtask

    // Reference outcome straight from the header/checksum rules.
    function automatic void model(input int n, input bit bad, output bit d, output int wl);
        if (n == 0)         begin d = 1'b1; wl = 0; end
        else if (n > MAXW)  begin d = 1'b0; wl = 0; end
        else                begin d = !bad; wl = n; end
    endfunction

    // gap: 0 back-to-back, 1 in_valid toggles every cycle, 2 random idle 0..2 cycles.
    task automatic run_load(input logic [15:0] n, input int gap, input bit bad, input bit glitch,
                            input bit exp_done, input int exp_wl, input string tag);
        logic [7:0] cs;
        logic [7:0] b;
        int         cnt;
        cs = 8'd0;
        clear_log();
        pulse_start();
        send_byte(n[7:0]);
        send_byte(n[15:8]);
        if (n >= 16'd1 && n <= 16'(MAXW)) begin
            for (int w = 0; w < int'(n); w++) begin
                for (int k = 0; k < 4; k++) begin
                    b  = pay_q[w][8*k +: 8];
                    cs = cs ^ b;
                    send_byte(b);
                    if (gap == 1) idle(1);
                    if (gap == 2) idle($urandom_range(0, 2));
                    if (glitch && w == 0 && k == 1) pulse_start();
                end
            end
`ifdef LOADER_CHECKSUM_EN
            send_byte(bad ? (cs ^ 8'h01) : cs);
`endif
        end
        idle(3);
        @(negedge clk);
        chk({tag, "_done"},      {31'd0, bus.done},      {31'd0, exp_done});
        chk({tag, "_error"},     {31'd0, bus.error},     {31'd0, !exp_done});
        chk({tag, "_cpu_reset"}, {31'd0, bus.cpu_reset}, {31'd0, !exp_done});
        chk({tag, "_busy"},      {31'd0, bus.busy},      32'd0);
        chk({tag, "_wl"},        32'(bus.words_loaded),  32'(exp_wl));
        chk({tag, "_nwrites"},   32'(wr_dat.size()),     32'(exp_wl));
        cnt = (wr_dat.size() < exp_wl) ? wr_dat.size() : exp_wl;
        for (int i = 0; i < cnt; i++) begin
            chk($sformatf("%s_addr%0d", tag, i), 32'(wr_addr[i]), 32'(BASE + 4 * i));
            chk($sformatf("%s_data%0d", tag, i), wr_dat[i], pay_q[i]);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog_timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] cs1;
        bit         d, bad, glitch;
        int         wl, n, r, gap;

        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_byte  = 8'd0;
        reset        = 1'b0;

        vecs[0] = '{16'd2,   32'h00100013, 32'h00200093, 0, 1'b1, 2};
        vecs[1] = '{16'd0,   32'h00000000, 32'h00000000, 0, 1'b1, 0};
        vecs[2] = '{16'd129, 32'h00000000, 32'h00000000, 0, 1'b0, 0};
        vecs[3] = '{16'd2,   32'h00100013, 32'h00200093, 1, 1'b1, 2};
        vecs[4] = '{16'd1,   32'hdeadbeef, 32'h00000000, 2, 1'b1, 1};

        check_reset_outputs("por");
        idle(1);
        reset = 1'b1;
        idle(1);

        // One-word load: write lands the cycle after byte 3, together with done.
        clear_log();
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h44);
        send_byte(8'h33);
        send_byte(8'h22);
        send_byte(8'h11);
        @(negedge clk);
        chk("lat_we",    {31'd0, bus.imem_we}, 32'd1);
        chk("lat_wdata", bus.imem_wdata,       32'h11223344);
        chk("lat_addr",  32'(bus.imem_addr),   32'(BASE));
`ifdef LOADER_CHECKSUM_EN
        chk("lat_done",  {31'd0, bus.done},    32'd0);
        @(posedge clk);
        #1;
        cs1 = 8'h11 ^ 8'h22 ^ 8'h33 ^ 8'h44;
        send_byte(cs1);
`else
        chk("lat_done",  {31'd0, bus.done},    32'd1);
`endif
        idle(2);
        @(negedge clk);
        chk("lat_wl",    32'(bus.words_loaded), 32'd1);
        chk("lat_cpu",   {31'd0, bus.cpu_reset}, 32'd0);
        @(posedge clk);
        #1;

        // Reset asserted after two of four payload bytes: everything clears, no write.
        clear_log();
        pulse_start();
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h13);
        send_byte(8'h00);
        reset = 1'b0;
        check_reset_outputs("midrst");
        idle(3);
        chk("midrst_nwrites", 32'(wr_dat.size()), 32'd0);
        reset = 1'b1;
        idle(1);

        for (int v = 0; v < 5; v++) begin
            pay_q.delete();
            pay_q.push_back(vecs[v].w0);
            pay_q.push_back(vecs[v].w1);
            run_load(vecs[v].n, vecs[v].gap, 1'b0, 1'b0, vecs[v].exp_done, vecs[v].exp_wl,
                     $sformatf("vec%0d", v));
        end

`ifdef LOADER_CHECKSUM_EN
        pay_q.delete();
        pay_q.push_back(32'h00100013);
        pay_q.push_back(32'h00200093);
        run_load(16'd2, 0, 1'b1, 1'b0, 1'b0, 2, "badcsum");
`endif

        for (int it = 0; it < 10; it++) begin
            r = $urandom_range(0, 9);
            if (r == 0)      n = 0;
            else if (r == 1) n = $urandom_range(MAXW + 1, 400);
            else if (it == 0 || r == 2) n = MAXW;
            else             n = $urandom_range(1, 6);
            pay_q.delete();
            for (int w = 0; w < n && w <= MAXW; w++) pay_q.push_back($urandom);
            bad = 1'b0;
`ifdef LOADER_CHECKSUM_EN
            bad = 1'($urandom_range(0, 1));
`endif
            gap    = $urandom_range(0, 2);
            glitch = 1'($urandom_range(0, 1));
            model(n, bad, d, wl);
            run_load(16'(n), gap, bad, glitch, d, wl, $sformatf("rnd%0d", it));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
